// File: rtl/ifu_fetch_buf.sv
// ifu_fetch_buf -- multi-cycle instruction fetch stage.
//
// Owns the fetch PC. Issues one read at a time to instruction memory over a
// req/rsp handshake with variable latency. Returned words go into a
// DEPTH-entry FIFO that is presented to the decoder as {pc, inst, err} over
// valid/ready. A redirect from exu flushes the FIFO and restarts fetch at the
// new PC. A response that was already in flight when the redirect arrived is
// discarded.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   redirect_i, redirect_pc_i         flush and restart fetch at redirect_pc_i
//   imem_req_valid_o/ready_i/addr_o   read request channel (addr word aligned)
//   imem_rsp_valid_i/data_i/err_i     read response, one per accepted request
//   out_valid_o/ready_i               buffer head handshake to idu
//   out_pc_o/inst_o/err_o             buffer head payload
//
// Optional build macro YSYX_23060251_IFU_MISALIGN_CHK_EN: a misaligned fetch
// PC is not sent to memory. Instead one faulting entry {fpc, nop, err=1} is
// pushed, and fetch then halts until the next redirect.
module ifu_fetch_buf #(
  parameter int                 PC_W     = 32,
  parameter int                 INST_W   = 32,
  parameter logic [PC_W-1:0]    RESET_PC = 'h8000_0000,
  parameter int                 DEPTH    = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              redirect_i,
  input  logic [PC_W-1:0]   redirect_pc_i,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [PC_W-1:0]   imem_req_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [INST_W-1:0] imem_rsp_data_i,
  input  logic              imem_rsp_err_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PC_W-1:0]   out_pc_o,
  output logic [INST_W-1:0] out_inst_o,
  output logic              out_err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              err;
  } entry_t;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   fpc_q, fpc_d;
  logic [PC_W-1:0]   req_pc_q, req_pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  entry_t            buf_q [DEPTH];

  logic   req_valid, slot_free, push, pop, flush;
  entry_t push_data;

`ifdef YSYX_23060251_IFU_MISALIGN_CHK_EN
  logic halt_q, halt_d;
`endif

  // Only one request can be outstanding, and nothing is pushed while in REQ.
  // A free slot seen here therefore stays reserved for the response.
  assign slot_free = (cnt_q < CNT_W'(DEPTH));

  assign out_valid_o = (cnt_q != '0) && !rst_i;
  assign pop         = out_valid_o && out_ready_i;

  always_comb begin
    state_d   = state_q;
    fpc_d     = fpc_q;
    req_pc_d  = req_pc_q;
    req_valid = 1'b0;
    push      = 1'b0;
    push_data = '0;
    flush     = 1'b0;
`ifdef YSYX_23060251_IFU_MISALIGN_CHK_EN
    halt_d    = halt_q;
`endif

    unique case (state_q)
      S_REQ: begin
`ifdef YSYX_23060251_IFU_MISALIGN_CHK_EN
        if (halt_q) begin
          req_valid = 1'b0;
        end else if (fpc_q[1:0] != 2'b00) begin
          // Emit the fault as a nop-carrying entry, then halt until redirect.
          if (slot_free) begin
            push      = 1'b1;
            push_data = '{pc: fpc_q, inst: INST_W'(32'h0000_0013), err: 1'b1};
            halt_d    = 1'b1;
          end
        end else begin
          req_valid = slot_free;
        end
`else
        req_valid = slot_free;
`endif
        if (req_valid && imem_req_ready_i) begin
          req_pc_d = fpc_q;
          fpc_d    = fpc_q + PC_W'(4);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid_i) begin
          push      = 1'b1;
          push_data = '{pc: req_pc_q, inst: imem_rsp_data_i, err: imem_rsp_err_i};
          state_d   = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rsp_valid_i) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    // Redirect wins over everything. A request still in flight must be
    // drained through DROP so that its response is never mistaken for the
    // new stream.
    if (redirect_i) begin
      req_valid = 1'b0;
      push      = 1'b0;
      flush     = 1'b1;
      fpc_d     = redirect_pc_i;
      req_pc_d  = req_pc_q;
`ifdef YSYX_23060251_IFU_MISALIGN_CHK_EN
      halt_d    = 1'b0;
`endif
      if (state_q == S_REQ || imem_rsp_valid_i) state_d = S_REQ;
      else                                      state_d = S_DROP;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      // Power-of-two depth lets the pointers wrap by plain overflow.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_REQ;
      fpc_q    <= RESET_PC;
      req_pc_q <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      req_pc_q <= req_pc_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

`ifdef YSYX_23060251_IFU_MISALIGN_CHK_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) halt_q <= 1'b0;
    else       halt_q <= halt_d;
  end
`endif

  // Payload storage needs no reset; cnt_q qualifies every read.
  always_ff @(posedge clk_i) begin
    if (push) buf_q[wr_ptr_q] <= push_data;
  end

  assign imem_req_valid_o = req_valid && !rst_i;
  assign imem_req_addr_o  = {fpc_q[PC_W-1:2], 2'b00};
  assign out_pc_o         = buf_q[rd_ptr_q].pc;
  assign out_inst_o       = buf_q[rd_ptr_q].inst;
  assign out_err_o        = buf_q[rd_ptr_q].err;

endmodule
